// File: rtl/sprite_pal_pkg.sv
// Shared types, constants and the round-robin pick function for the sprite palette arbiter.
// Purely declarative: no state, no timing, no flow control.
package sprite_pal_pkg;

    localparam int          PAL_DEPTH   = 16;
    localparam logic [11:0] RGB_WHITE   = 12'hFFF;
    localparam int          DEF_NUM_REQ = 4;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb12_t;

    // One-hot pick of the first set req bit scanning upward from ptr, wrapping at n (n <= 8).
    function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
        logic [7:0] g;
        logic       found;
        int         j;
        g     = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            j = (int'(ptr) + i) % n;
            if (i < n && !found && req[3'(j)]) begin
                g[3'(j)] = 1'b1;
                found    = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/sprite_palette_rom.sv
// Constant 16-entry 12-bit sprite palette; entry 1 is the white transparent key colour.
// Combinational lookup, zero latency, no backpressure.
module sprite_palette_rom
    import sprite_pal_pkg::*;
(
    input  logic [3:0] index,
    output rgb12_t     rgb
);

    localparam rgb12_t PAL [PAL_DEPTH] = '{
        12'h000, 12'hFFF, 12'hF00, 12'h0F0,
        12'h00F, 12'hFF0, 12'h0FF, 12'hF0F,
        12'h888, 12'h444, 12'hF80, 12'h8F0,
        12'h08F, 12'h840, 12'h4A2, 12'hCCC
    };

    assign rgb = PAL[index];

endmodule

// File: rtl/sprite_palette_arbiter.sv
// Round-robin share of one sprite palette between NUM_REQ layers; optional hit-flash under HIT_FLASH_EN.
// Registered response one cycle after grant; requesters hold req until their gnt bit is seen.
module sprite_palette_arbiter
    import sprite_pal_pkg::*;
#(
    parameter int               NUM_REQ    = DEF_NUM_REQ,
    parameter int               IDX_W      = 4,
    parameter logic [IDX_W-1:0] TRANSP_IDX = IDX_W'(1)
`ifdef HIT_FLASH_EN
    ,
    parameter int               FLASH_FRAMES = 8
`endif
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic                       rsp_transp,
    output logic [3:0]                 red,
    output logic [3:0]                 green,
    output logic [3:0]                 blue
`ifdef HIT_FLASH_EN
    ,
    input  logic                       frame_tick,
    input  logic [NUM_REQ-1:0]         flash
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  gnt_id;
    logic [7:0]       pick;
    logic             any_gnt;
    logic [IDX_W-1:0] sel_idx;
    rgb12_t           pal_rgb;
    rgb12_t           rsp_rgb;

    assign pick    = rr_pick(8'(req), 3'(rr_ptr), NUM_REQ);
    assign any_gnt = (|pick) & ~Reset;
    assign gnt     = Reset ? '0 : pick[NUM_REQ-1:0];

    always_comb begin
        gnt_id  = '0;
        sel_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick[k]) begin
                gnt_id  = ID_W'(k);
                sel_idx = idx[k*IDX_W +: IDX_W];
            end
        end
    end

    sprite_palette_rom u_rom (
        .index (sel_idx),
        .rgb   (pal_rgb)
    );

`ifdef HIT_FLASH_EN
    localparam int FC_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    logic [FC_W-1:0] flash_cnt;
    logic            flash_phase;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            flash_cnt   <= '0;
            flash_phase <= 1'b0;
        end else if (frame_tick) begin
            if (flash_cnt == FC_W'(FLASH_FRAMES - 1)) begin
                flash_cnt   <= '0;
                flash_phase <= ~flash_phase;
            end else begin
                flash_cnt <= flash_cnt + FC_W'(1);
            end
        end
    end

    // Flash overrides colour only; transparency still follows the index.
    assign rsp_rgb = (flash_phase && |(flash & pick[NUM_REQ-1:0])) ? rgb12_t'(RGB_WHITE) : pal_rgb;
`else
    assign rsp_rgb = pal_rgb;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rr_ptr     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_transp <= 1'b0;
            {red, green, blue} <= '0;
        end else if (any_gnt) begin
            rr_ptr     <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
            rsp_valid  <= 1'b1;
            rsp_id     <= gnt_id;
            rsp_transp <= (sel_idx == TRANSP_IDX);
            {red, green, blue} <= rsp_rgb;
        end else begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// Randomised self-checking bench for sprite_palette_arbiter against a cycle-level reference model.
// Covers HIT_FLASH_EN scenarios when that macro is defined for the build.
module tb_sprite_palette_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  req;
    logic [15:0] idx;
    logic [3:0]  gnt;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic        rsp_transp;
    logic [3:0]  red, green, blue;
`ifdef HIT_FLASH_EN
    logic        frame_tick;
    logic [3:0]  flash;
`endif

    always #5 Clk = ~Clk;

    sprite_palette_arbiter #(
        .NUM_REQ    (4),
        .IDX_W      (4),
        .TRANSP_IDX (4'h1)
`ifdef HIT_FLASH_EN
        ,
        .FLASH_FRAMES (2)
`endif
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req        (req),
        .idx        (idx),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_transp (rsp_transp),
        .red        (red),
        .green      (green),
        .blue       (blue)
`ifdef HIT_FLASH_EN
        ,
        .frame_tick (frame_tick),
        .flash      (flash)
`endif
    );

    logic [11:0] pal_ref [16] = '{
        12'h000, 12'hFFF, 12'hF00, 12'h0F0,
        12'h00F, 12'hFF0, 12'h0FF, 12'hF0F,
        12'h888, 12'h444, 12'hF80, 12'h8F0,
        12'h08F, 12'h840, 12'h4A2, 12'hCCC
    };

    int          m_ptr;
    logic        m_vld;
    logic [1:0]  m_id;
    logic        m_transp;
    logic [11:0] m_rgb;
    int          m_fcnt;
    logic        m_phase;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [3:0] exp_gnt(input logic [3:0] r);
        logic [3:0] oh;
        int         j;
        oh = '0;
        for (int i = 0; i < 4; i++) begin
            j = (m_ptr + i) % 4;
            if (oh == 4'b0 && r[2'(j)]) oh[2'(j)] = 1'b1;
        end
        return oh;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_vld = 0; m_id = 0; m_transp = 0; m_rgb = 0; m_fcnt = 0; m_phase = 0;
    endtask

    // Advances one clock edge and applies the expected effect of the current inputs.
    task automatic cycle();
        logic [3:0] g;
        logic [3:0] ki;
        int         k;
        g = exp_gnt(req);
        k = 0;
        for (int i = 0; i < 4; i++) if (g[i]) k = i;
        ki = idx[k*4 +: 4];
        @(posedge Clk);
        if (g != 4'b0) begin
            m_vld    = 1'b1;
            m_id     = 2'(k);
            m_transp = (ki == 4'h1);
            m_rgb    = pal_ref[ki];
`ifdef HIT_FLASH_EN
            if (flash[2'(k)] && m_phase) m_rgb = 12'hFFF;
`endif
            m_ptr = (k + 1) % 4;
        end else begin
            m_vld = 1'b0;
        end
`ifdef HIT_FLASH_EN
        if (frame_tick) begin
            if (m_fcnt == 1) begin m_fcnt = 0; m_phase = ~m_phase; end
            else m_fcnt++;
        end
`endif
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; req = 4'b1111; idx = 16'($urandom);
        model_reset();
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        checks++;
        if ({rsp_valid, rsp_id, rsp_transp, red, green, blue} !== 19'd0) begin
            errors++; $display("FAIL reset_rsp got %b want all zero", {rsp_valid, rsp_id, rsp_transp, red, green, blue});
        end
        @(negedge Clk); Reset = 1'b0; #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt got %b want 0001", gnt); end
        for (int i = 0; i < 3; i++) begin
            idx = 16'($urandom);
            cycle();
            checks++;
            if ({rsp_valid, rsp_id, rsp_transp, red, green, blue} !== {m_vld, m_id, m_transp, m_rgb}) begin
                errors++; $display("FAIL reset_run rsp got %b want %b", {rsp_valid, rsp_id, rsp_transp, red, green, blue}, {m_vld, m_id, m_transp, m_rgb});
            end
        end
        Reset = 1'b1; model_reset(); #1;
        checks++;
        if ({gnt, rsp_valid} !== 5'b0) begin errors++; $display("FAIL reset_mid got gnt=%b vld=%b want 0000/0", gnt, rsp_valid); end
        Reset = 1'b0; #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_mid_release got %b want 0001", gnt); end
    endtask

    task automatic test_single();
        req = 4'b0100; idx = 16'($urandom); idx[11:8] = 4'h3;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b want 0100", gnt); end
            cycle();
            checks++;
            if ({rsp_valid, rsp_id, red, green, blue} !== {1'b1, 2'd2, pal_ref[3]}) begin
                errors++; $display("FAIL single_rsp got %b want %b", {rsp_valid, rsp_id, red, green, blue}, {1'b1, 2'd2, pal_ref[3]});
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        req = 4'b1000; cycle();
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            idx  = 16'($urandom);
            want = 4'b0001 << (i % 4);
            #1;
            checks++; if (gnt !== want) begin errors++; $display("FAIL rr_gnt step %0d got %b want %b", i, gnt, want); end
            cycle();
            checks++;
            if ({rsp_valid, rsp_id, rsp_transp, red, green, blue} !== {m_vld, m_id, m_transp, m_rgb} || rsp_id !== 2'(i % 4)) begin
                errors++; $display("FAIL rr_rsp step %0d got id=%0d rgb=%h want id=%0d rgb=%h", i, rsp_id, {red, green, blue}, i % 4, m_rgb);
            end
        end
    endtask

    task automatic test_wrap_skip();
        req = 4'b0100; cycle();
        req = 4'b1010; #1;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_gnt got %b want 1000", gnt); end
        cycle(); #1;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL skip_gnt got %b want 0010", gnt); end
        cycle();
        checks++; if ({rsp_valid, rsp_id} !== 3'b101) begin errors++; $display("FAIL skip_rsp got vld=%b id=%0d want 1/1", rsp_valid, rsp_id); end
    endtask

    task automatic test_transparency();
        req = 4'b0001; idx[3:0] = 4'h1;
        cycle();
        checks++;
        if ({rsp_transp, red, green, blue} !== {1'b1, 12'hFFF}) begin
            errors++; $display("FAIL transp_key got t=%b rgb=%h want 1/fff", rsp_transp, {red, green, blue});
        end
        idx[3:0] = 4'h0;
        cycle();
        checks++;
        if ({rsp_transp, red, green, blue} !== {1'b0, pal_ref[0]}) begin
            errors++; $display("FAIL transp_zero got t=%b rgb=%h want 0/%h", rsp_transp, {red, green, blue}, pal_ref[0]);
        end
        req = 4'b0000; #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL idle_gnt got %b want 0000", gnt); end
        cycle();
        checks++;
        if ({rsp_valid, rsp_id, rsp_transp, red, green, blue} !== {1'b0, 2'd0, 1'b0, pal_ref[0]}) begin
            errors++; $display("FAIL idle_hold got %b want %b", {rsp_valid, rsp_id, rsp_transp, red, green, blue}, {1'b0, 2'd0, 1'b0, pal_ref[0]});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            req = 4'($urandom); idx = 16'($urandom);
`ifdef HIT_FLASH_EN
            frame_tick = ($urandom_range(0, 3) == 0);
`endif
            #1;
            checks++; if (gnt !== exp_gnt(req)) begin errors++; $display("FAIL rand_gnt step %0d got %b want %b", i, gnt, exp_gnt(req)); end
            cycle();
            checks++;
            if ({rsp_valid, rsp_id, rsp_transp, red, green, blue} !== {m_vld, m_id, m_transp, m_rgb}) begin
                errors++; $display("FAIL rand_rsp step %0d got %b want %b", i, {rsp_valid, rsp_id, rsp_transp, red, green, blue}, {m_vld, m_id, m_transp, m_rgb});
            end
        end
`ifdef HIT_FLASH_EN
        frame_tick = 1'b0;
`endif
    endtask

`ifdef HIT_FLASH_EN
    task automatic test_flash();
        Reset = 1'b1; req = 4'b0000; flash = 4'b0001; frame_tick = 1'b0;
        model_reset(); #1; Reset = 1'b0;
        idx = 16'($urandom); idx[3:0] = 4'h2; idx[7:4] = 4'h3;
        frame_tick = 1'b1; cycle(); cycle(); frame_tick = 1'b0;
        req = 4'b0011; cycle();
        checks++;
        if ({rsp_id, red, green, blue} !== {2'd0, 12'hFFF} || {red, green, blue} !== m_rgb) begin
            errors++; $display("FAIL flash_on got id=%0d rgb=%h want 0/fff", rsp_id, {red, green, blue});
        end
        cycle();
        checks++;
        if ({rsp_id, red, green, blue} !== {2'd1, pal_ref[3]}) begin
            errors++; $display("FAIL flash_other got id=%0d rgb=%h want 1/%h", rsp_id, {red, green, blue}, pal_ref[3]);
        end
        req = 4'b0000; frame_tick = 1'b1; cycle(); cycle(); frame_tick = 1'b0;
        req = 4'b0001; cycle();
        checks++;
        if ({rsp_id, red, green, blue} !== {2'd0, pal_ref[2]}) begin
            errors++; $display("FAIL flash_off got id=%0d rgb=%h want 0/%h", rsp_id, {red, green, blue}, pal_ref[2]);
        end
        flash = 4'b0000; req = 4'b0000;
    endtask
`endif

    initial begin
`ifdef HIT_FLASH_EN
        frame_tick = 1'b0; flash = 4'b0000;
`endif
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_transparency();
        test_random();
`ifdef HIT_FLASH_EN
        test_flash();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
